// File: rtl/cache_fill_pkg.sv
// Shared state encoding and width helpers for the cache-line fill controller.
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fill_state_e;

  function automatic int idx_width(input int words_per_block);
    return (words_per_block > 1) ? $clog2(words_per_block) : 1;
  endfunction

  // Must hold the value MAX_OUTSTANDING itself, hence the +1.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/cache_fill_if.sv
// Miss/memory/array handshake bundle; master is the fill controller, slave is its environment.
interface cache_fill_if #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int IDX_W = cache_fill_pkg::idx_width(WORDS_PER_BLOCK);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              mem_req;
  logic              mem_ready;
  logic [ADDR_W-1:0] memory_address;
  logic [DATA_W-1:0] memory_data_in;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              write_data_array;
  logic              write_tag_array;
  logic [IDX_W-1:0]  fill_word_index;
  logic [DATA_W-1:0] memory_data_out;

  modport master (
    input  miss_detected, miss_address, mem_ready, memory_data_in, memory_data_valid,
    output mem_req, memory_address, fsm_busy, write_data_array, write_tag_array,
           fill_word_index, memory_data_out
  );

  modport slave (
    output miss_detected, miss_address, mem_ready, memory_data_in, memory_data_valid,
    input  mem_req, memory_address, fsm_busy, write_data_array, write_tag_array,
           fill_word_index, memory_data_out
  );

endinterface

// File: rtl/cache_fill_addr_gen.sv
// Maps a fill counter onto a wrapped word slot and its byte address within the block.
module cache_fill_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 3,
  parameter int BYTE_W = 1
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [IDX_W-1:0]  start_i,
  input  logic [IDX_W-1:0]  count_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic [ADDR_W-1:0] addr_o
);

  // Block size is a power of two, so natural overflow gives the modulo wrap.
  assign idx_o  = start_i + count_i;
  assign addr_o = base_i | (ADDR_W'(idx_o) << BYTE_W);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache-line fill controller: pipelined in-order block fetch with bounded outstanding requests.
// Define CACHE_FILL_CWF_EN for critical-word-first ordering; otherwise fills run linearly from word 0.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst,
  cache_fill_if.master bus
);

  localparam int IDX_W  = idx_width(WORDS_PER_BLOCK);
  localparam int CNT_W  = cnt_width(MAX_OUTSTANDING);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int OFF_W  = IDX_W + BYTE_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  fill_state_e       state_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [IDX_W-1:0]  start_q, issue_cnt_q, ret_cnt_q;
  logic [CNT_W-1:0]  outst_q, outst_d;

  logic              idle, accept, resp, last_resp, last_issue;
  logic [ADDR_W-1:0] miss_base, gen_base, next_addr, ret_addr_unused;
  logic [IDX_W-1:0]  miss_start, gen_start, gen_cnt, ret_idx, issue_idx_unused;

  assign idle       = (state_q == IDLE);
  assign accept     = bus.mem_req && bus.mem_ready;
  assign resp       = bus.memory_data_valid && !idle;
  assign last_resp  = resp && (ret_cnt_q == LAST_IDX);
  assign last_issue = accept && (issue_cnt_q == LAST_IDX);
  assign miss_base  = bus.miss_address & ~OFF_MASK;

`ifdef CACHE_FILL_CWF_EN
  assign miss_start = IDX_W'(bus.miss_address >> BYTE_W);
`else
  assign miss_start = '0;
`endif

  // In IDLE the generator precomputes the first request address from the live miss.
  assign gen_base  = idle ? miss_base  : base_q;
  assign gen_start = idle ? miss_start : start_q;
  assign gen_cnt   = idle ? '0         : issue_cnt_q + IDX_ONE;

  cache_fill_addr_gen #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .BYTE_W(BYTE_W)) u_issue_gen (
    .base_i (gen_base),
    .start_i(gen_start),
    .count_i(gen_cnt),
    .idx_o  (issue_idx_unused),
    .addr_o (next_addr)
  );

  cache_fill_addr_gen #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .BYTE_W(BYTE_W)) u_ret_gen (
    .base_i (base_q),
    .start_i(start_q),
    .count_i(ret_cnt_q),
    .idx_o  (ret_idx),
    .addr_o (ret_addr_unused)
  );

  always_comb begin
    outst_d = outst_q;
    if (accept && !resp) begin
      outst_d = outst_q + CNT_ONE;
    end else if (!accept && resp) begin
      outst_d = outst_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      outst_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.miss_detected) begin
            state_q     <= ISSUE;
            base_q      <= miss_base;
            start_q     <= miss_start;
            addr_q      <= next_addr;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            outst_q     <= '0;
          end
        end
        ISSUE: begin
          // The address only moves on acceptance and freezes on the final request.
          if (accept) begin
            issue_cnt_q <= issue_cnt_q + IDX_ONE;
            if (last_issue) begin
              state_q <= DRAIN;
            end else begin
              addr_q <= next_addr;
            end
          end
        end
        DRAIN: begin
        end
        default: state_q <= IDLE;
      endcase
      if (!idle) begin
        outst_q <= outst_d;
        if (resp) begin
          ret_cnt_q <= ret_cnt_q + IDX_ONE;
        end
        if (last_resp) begin
          state_q <= IDLE;
        end
      end
    end
  end

  // A response may land with MAX_OUTSTANDING in flight, freeing a slot in the same cycle.
  assign bus.mem_req          = (state_q == ISSUE) && ((outst_q < MAX_CNT) || bus.memory_data_valid);
  assign bus.memory_address   = addr_q;
  assign bus.fsm_busy         = (idle && bus.miss_detected) || (!idle && !last_resp);
  assign bus.write_data_array = resp;
  assign bus.write_tag_array  = last_resp;
  assign bus.fill_word_index  = ret_idx;
  assign bus.memory_data_out  = bus.memory_data_in;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: two instances (MAX_OUTSTANDING 4 and 2) with a latency memory model.
module tb_cache_fill_ctrl;

`ifdef CACHE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam logic [15:0] IDLE_DATA = 16'h5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Stimulus per instance
  logic        miss_det   [2] = '{1'b0, 1'b0};
  logic [15:0] miss_addr  [2] = '{16'h0, 16'h0};
  int          lat        [2] = '{4, 4};
  int          stall_from [2] = '{0, 0};
  int          stall_len  [2] = '{0, 0};

  // Memory model drive
  logic        m_v   [2] = '{1'b0, 1'b0};
  logic        m_rdy [2] = '{1'b1, 1'b1};
  logic [15:0] m_d   [2] = '{IDLE_DATA, IDLE_DATA};

  // DUT output mirrors
  logic        o_req [2];
  logic [15:0] o_addr[2];
  logic        o_busy[2];
  logic        o_wda [2];
  logic        o_wta [2];
  logic [2:0]  o_idx [2];
  logic [15:0] o_dout[2];

  for (genvar gi = 0; gi < 2; gi++) begin : g
    cache_fill_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) bus ();
    cache_fill_ctrl #(
      .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .MAX_OUTSTANDING((gi == 0) ? 4 : 2)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.miss_detected     = miss_det[gi];
    assign bus.miss_address      = miss_addr[gi];
    assign bus.mem_ready         = m_rdy[gi];
    assign bus.memory_data_valid = m_v[gi];
    assign bus.memory_data_in    = m_d[gi];
    assign o_req[gi]  = bus.mem_req;
    assign o_addr[gi] = bus.memory_address;
    assign o_busy[gi] = bus.fsm_busy;
    assign o_wda[gi]  = bus.write_data_array;
    assign o_wta[gi]  = bus.write_tag_array;
    assign o_idx[gi]  = bus.fill_word_index;
    assign o_dout[gi] = bus.memory_data_out;
  end

  // Model state and logs (written only by the model process)
  logic [15:0] q_addr [2][16];
  int          q_due  [2][16];
  int          q_head [2];
  int          q_tail [2];
  int          outst  [2];
  int          peak   [2];
  int          ovf_bad[2];
  int          hold_bad[2];
  int          busy_bad[2];
  logic        prev_pend[2];
  logic [15:0] prev_addr[2];
  logic [15:0] req_log[2][128];
  int          req_n  [2];
  logic [15:0] wr_data[2][128];
  logic [2:0]  wr_idx [2][128];
  int          wr_n   [2];
  int          tag_cnt[2];
  int          tag_cyc[2];
  logic [15:0] tag_data[2];
  logic        tag_busy[2];
  logic [2:0]  tag_idx[2];

  // Memory: in-order responses L cycles after acceptance; words carry (word slot + 1).
  always @(negedge clk) begin
    bit acc;
    #1;
    for (int gi = 0; gi < 2; gi++) begin
      if (rst) begin
        q_head[gi] = 0; q_tail[gi] = 0; outst[gi] = 0; prev_pend[gi] = 1'b0;
        m_v[gi] = 1'b0; m_d[gi] = IDLE_DATA; m_rdy[gi] = 1'b1;
      end else begin
        m_rdy[gi] = !(cyc >= stall_from[gi] && cyc < stall_from[gi] + stall_len[gi]);
        if (q_head[gi] != q_tail[gi] && q_due[gi][q_head[gi] % 16] <= cyc) begin
          m_v[gi] = 1'b1;
          m_d[gi] = 16'(q_addr[gi][q_head[gi] % 16][3:1]) + 16'd1;
          q_head[gi]++;
        end else begin
          m_v[gi] = 1'b0;
          m_d[gi] = IDLE_DATA;
        end
      end
    end
    #1;
    for (int gi = 0; gi < 2; gi++) begin
      if (!rst) begin
        acc = o_req[gi] && m_rdy[gi];
        if (o_req[gi] && outst[gi] >= ((gi == 0) ? 4 : 2) && !m_v[gi]) ovf_bad[gi]++;
        if (prev_pend[gi] && o_addr[gi] != prev_addr[gi]) hold_bad[gi]++;
        if (acc) begin
          q_addr[gi][q_tail[gi] % 16] = o_addr[gi];
          q_due[gi][q_tail[gi] % 16]  = cyc + lat[gi];
          q_tail[gi]++;
          req_log[gi][req_n[gi] % 128] = o_addr[gi];
          req_n[gi]++;
        end
        if (o_wda[gi]) begin
          wr_data[gi][wr_n[gi] % 128] = o_dout[gi];
          wr_idx[gi][wr_n[gi] % 128]  = o_idx[gi];
          wr_n[gi]++;
          if (!o_wta[gi] && !o_busy[gi]) busy_bad[gi]++;
        end
        if (o_wta[gi]) begin
          tag_cnt[gi]++;
          tag_cyc[gi]  = cyc;
          tag_data[gi] = o_dout[gi];
          tag_busy[gi] = o_busy[gi];
          tag_idx[gi]  = o_idx[gi];
        end
        outst[gi] = outst[gi] + (acc ? 1 : 0) - (m_v[gi] ? 1 : 0);
        if (outst[gi] > peak[gi]) peak[gi] = outst[gi];
        prev_pend[gi] = o_req[gi] && !m_rdy[gi];
        prev_addr[gi] = o_addr[gi];
      end
    end
  end

  // Call right after a negedge. Holds miss until the tag write, then drops it or retargets it.
  task automatic do_fill(input int gi, input logic [15:0] addr, input int l, input int s_off,
                         input int s_len, input bit chain, input logic [15:0] chain_addr,
                         output int lat_out, output bit timeout);
    int c0, t0;
    lat[gi] = l; stall_from[gi] = cyc + s_off; stall_len[gi] = s_len;
    miss_det[gi] = 1'b1; miss_addr[gi] = addr;
    c0 = cyc; t0 = tag_cnt[gi];
    timeout = 1'b1; lat_out = -1;
    for (int i = 0; i < 200; i++) begin
      #3;
      if (tag_cnt[gi] != t0) begin
        timeout = 1'b0;
        lat_out = tag_cyc[gi] - c0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (chain) miss_addr[gi] = chain_addr;
    else miss_det[gi] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      checks++; if (o_req[0] !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", o_req[0]); end
      checks++; if (o_busy[0] !== 1'b0 || o_busy[1] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b want 0/0", o_busy[0], o_busy[1]); end
      checks++; if (o_wda[0] !== 1'b0 || o_wta[0] !== 1'b0) begin errors++; $display("FAIL reset_writes got %b%b want 00", o_wda[0], o_wta[0]); end
      checks++; if (o_addr[0] !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", o_addr[0]); end
      checks++; if (o_idx[0] !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", o_idx[0]); end
      checks++; if (o_dout[0] !== IDLE_DATA) begin errors++; $display("FAIL reset_dout got %h want %h", o_dout[0], IDLE_DATA); end
    end
  endtask

  task automatic test_linear_fill();
    int l, rb, wb, st, w;
    bit to;
    logic [15:0] a;
    @(negedge clk);
    rb = req_n[0]; wb = wr_n[0];
    st = CWF ? 1 : 0;
    do_fill(0, 16'hFFF3, 4, 0, 0, 1'b0, 16'h0, l, to);
    checks++; if (to) begin errors++; $display("FAIL linear_done got timeout want tag write"); end
    checks++; if (l !== 12) begin errors++; $display("FAIL linear_latency got %0d want 12", l); end
    checks++; if (req_n[0] - rb !== 8 || wr_n[0] - wb !== 8) begin errors++; $display("FAIL linear_counts got %0d/%0d want 8/8", req_n[0] - rb, wr_n[0] - wb); end
    for (int k = 0; k < 8; k++) begin
      w = (st + k) % 8;
      a = 16'hFFF0 + 16'(2 * w);
      checks++; if (req_log[0][(rb + k) % 128] !== a) begin errors++; $display("FAIL linear_addr[%0d] got %h want %h", k, req_log[0][(rb + k) % 128], a); end
      checks++; if (wr_data[0][(wb + k) % 128] !== 16'(w + 1) || wr_idx[0][(wb + k) % 128] !== 3'(w)) begin errors++; $display("FAIL linear_write[%0d] got %h@%0d want %h@%0d", k, wr_data[0][(wb + k) % 128], wr_idx[0][(wb + k) % 128], w + 1, w); end
    end
    checks++; if (tag_data[0] !== 16'(((st + 7) % 8) + 1)) begin errors++; $display("FAIL linear_tag_data got %h want %h", tag_data[0], ((st + 7) % 8) + 1); end
    checks++; if (tag_busy[0] !== 1'b0) begin errors++; $display("FAIL linear_tag_busy got %b want 0", tag_busy[0]); end
    checks++; if (busy_bad[0] !== 0) begin errors++; $display("FAIL linear_busy_low got %0d want 0", busy_bad[0]); end
  endtask

  task automatic test_max_outstanding();
    int l, rb, wb, st, w;
    bit to;
    logic [15:0] a;
    @(negedge clk);
    rb = req_n[1]; wb = wr_n[1];
    st = CWF ? 6 : 0;
    do_fill(1, 16'h4A5C, 4, 0, 0, 1'b0, 16'h0, l, to);
    checks++; if (to) begin errors++; $display("FAIL maxout_done got timeout want tag write"); end
    checks++; if (l !== 18) begin errors++; $display("FAIL maxout_latency got %0d want 18", l); end
    checks++; if (ovf_bad[1] !== 0) begin errors++; $display("FAIL maxout_overissue got %0d want 0", ovf_bad[1]); end
    checks++; if (peak[1] !== 2) begin errors++; $display("FAIL maxout_peak got %0d want 2", peak[1]); end
    for (int k = 0; k < 8; k++) begin
      w = (st + k) % 8;
      a = 16'h4A50 + 16'(2 * w);
      checks++; if (req_log[1][(rb + k) % 128] !== a || wr_data[1][(wb + k) % 128] !== 16'(w + 1)) begin errors++; $display("FAIL maxout_word[%0d] got %h/%h want %h/%h", k, req_log[1][(rb + k) % 128], wr_data[1][(wb + k) % 128], a, w + 1); end
    end
  endtask

  task automatic test_ready_stall();
    int l, rb, wb, st, w;
    bit to;
    logic [15:0] a;
    @(negedge clk);
    rb = req_n[0]; wb = wr_n[0];
    st = CWF ? 2 : 0;
    do_fill(0, 16'h1234, 2, 3, 3, 1'b0, 16'h0, l, to);
    checks++; if (to) begin errors++; $display("FAIL stall_done got timeout want tag write"); end
    checks++; if (l !== 13) begin errors++; $display("FAIL stall_latency got %0d want 13", l); end
    checks++; if (hold_bad[0] !== 0) begin errors++; $display("FAIL stall_addr_hold got %0d changes want 0", hold_bad[0]); end
    checks++; if (req_n[0] - rb !== 8 || wr_n[0] - wb !== 8) begin errors++; $display("FAIL stall_counts got %0d/%0d want 8/8", req_n[0] - rb, wr_n[0] - wb); end
    for (int k = 0; k < 8; k++) begin
      w = (st + k) % 8;
      a = 16'h1230 + 16'(2 * w);
      checks++; if (req_log[0][(rb + k) % 128] !== a || wr_data[0][(wb + k) % 128] !== 16'(w + 1)) begin errors++; $display("FAIL stall_word[%0d] got %h/%h want %h/%h", k, req_log[0][(rb + k) % 128], wr_data[0][(wb + k) % 128], a, w + 1); end
    end
  endtask

  task automatic test_cwf_order();
    int l, rb, wb, st, w;
    bit to;
    logic [15:0] a;
    @(negedge clk);
    rb = req_n[0]; wb = wr_n[0];
    st = CWF ? 3 : 0;
    do_fill(0, 16'h0026, 3, 0, 0, 1'b0, 16'h0, l, to);
    checks++; if (to || l !== 11) begin errors++; $display("FAIL cwf_latency got %0d (timeout %b) want 11", l, to); end
    for (int k = 0; k < 8; k++) begin
      w = (st + k) % 8;
      a = 16'h0020 + 16'(2 * w);
      checks++; if (req_log[0][(rb + k) % 128] !== a) begin errors++; $display("FAIL cwf_addr[%0d] got %h want %h", k, req_log[0][(rb + k) % 128], a); end
      checks++; if (wr_idx[0][(wb + k) % 128] !== 3'(w)) begin errors++; $display("FAIL cwf_index[%0d] got %0d want %0d", k, wr_idx[0][(wb + k) % 128], w); end
    end
    checks++; if (tag_idx[0] !== 3'((st + 7) % 8)) begin errors++; $display("FAIL cwf_tag_index got %0d want %0d", tag_idx[0], (st + 7) % 8); end
  endtask

  task automatic test_reset_mid_fill();
    int l, rb, wb, st, w;
    bit to, ok;
    logic [15:0] a;
    @(negedge clk);
    lat[0] = 2; stall_len[0] = 0; wb = wr_n[0];
    miss_addr[0] = 16'h0040; miss_det[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (wr_n[0] - wb >= 3) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_responses got %0d want 3", wr_n[0] - wb); end
    @(negedge clk);
    rst = 1'b1; miss_det[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #3;
    checks++; if (o_busy[0] !== 1'b0 || o_req[0] !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy %b req %b want 0 0", o_busy[0], o_req[0]); end
    checks++; if (o_addr[0] !== 16'h0) begin errors++; $display("FAIL rstmid_addr got %h want 0000", o_addr[0]); end
    @(negedge clk);
    rb = req_n[0]; wb = wr_n[0];
    st = CWF ? 1 : 0;
    do_fill(0, 16'h0023, 2, 0, 0, 1'b0, 16'h0, l, to);
    checks++; if (to || l !== 10) begin errors++; $display("FAIL rstmid_latency got %0d (timeout %b) want 10", l, to); end
    checks++; if (req_n[0] - rb !== 8 || wr_n[0] - wb !== 8) begin errors++; $display("FAIL rstmid_counts got %0d/%0d want 8/8", req_n[0] - rb, wr_n[0] - wb); end
    for (int k = 0; k < 8; k++) begin
      w = (st + k) % 8;
      a = 16'h0020 + 16'(2 * w);
      checks++; if (req_log[0][(rb + k) % 128] !== a || wr_data[0][(wb + k) % 128] !== 16'(w + 1)) begin errors++; $display("FAIL rstmid_word[%0d] got %h/%h want %h/%h", k, req_log[0][(rb + k) % 128], wr_data[0][(wb + k) % 128], a, w + 1); end
    end
    checks++; if (tag_idx[0] !== 3'((st + 7) % 8)) begin errors++; $display("FAIL rstmid_tag_index got %0d want %0d", tag_idx[0], (st + 7) % 8); end
  endtask

  task automatic test_back_to_back();
    int l1, l2, rb, tc;
    bit t1, t2;
    logic [15:0] a;
    @(negedge clk);
    rb = req_n[0]; tc = tag_cnt[0];
    do_fill(0, 16'h0100, 3, 0, 0, 1'b1, 16'h0208, l1, t1);
    do_fill(0, 16'h0208, 3, 0, 0, 1'b0, 16'h0, l2, t2);
    checks++; if (t1 || l1 !== 11) begin errors++; $display("FAIL b2b_first got %0d (timeout %b) want 11", l1, t1); end
    checks++; if (t2 || l2 !== 11) begin errors++; $display("FAIL b2b_second got %0d (timeout %b) want 11", l2, t2); end
    checks++; if (tag_cnt[0] - tc !== 2 || req_n[0] - rb !== 16) begin errors++; $display("FAIL b2b_counts got %0d tags %0d reqs want 2 16", tag_cnt[0] - tc, req_n[0] - rb); end
    a = CWF ? 16'h0208 : 16'h0200;
    checks++; if (req_log[0][(rb + 8) % 128] !== a) begin errors++; $display("FAIL b2b_first_addr got %h want %h", req_log[0][(rb + 8) % 128], a); end
  endtask

  initial begin
    test_reset();
    test_linear_fill();
    test_max_outstanding();
    test_ready_stall();
    test_cwf_order();
    test_reset_mid_fill();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
